pico_wb_master: RTL and testbench
=================================

Name: pico_wb_master

Overview:
Bridges the PicoRV32 native memory interface to a Wishbone classic (single-transfer) initiator. The block turns one mem_valid request into exactly one Wishbone cycle and returns read data and mem_ready to the core. It sits between the CPU and the Wishbone slave peripherals, such as the register blocks, on the same bus. A bus timeout and error path keep the core from hanging on an unmapped address.

Parameters:
TIMEOUT, 255, Wishbone cycles spent in BUSY before forced termination; 0 disables the timeout; max 65535.

Ports:
wb_clk_i  in  1  system clock, rising edge
arst_i  in  1  asynchronous reset, active high
mem_valid  in  1  core request valid
mem_addr  in  32  core byte address
mem_wdata  in  32  core write data
mem_wstrb  in  4  byte write strobes; 0 = read
mem_ready  out  1  one-cycle completion pulse to core
mem_rdata  out  32  read data to core
wb_adr_o  out  32  Wishbone address, word aligned
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_sel_o  out  4  byte selects
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  bus cycle valid
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error
err_o  out  1  one-cycle pulse: transfer ended by wb_err_i or timeout

Behaviour:
- Reset (arst_i=1, async): state IDLE, all outputs 0 (including mem_rdata), timeout counter 0. The reset takes effect immediately, mid-cycle, and drops cyc/stb without waiting for a clock edge.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, BUSY, DONE.
- IDLE, mem_valid=1 sampled:
  - wb_adr_o <= {mem_addr[31:2],2'b00}
  - wb_dat_o <= mem_wdata
  - wb_we_o <= |mem_wstrb
  - wb_sel_o <= (mem_wstrb!=0) ? mem_wstrb : 4'hF
  - wb_cyc_o, wb_stb_o <= 1; counter <= 0; go to BUSY
- BUSY: cyc/stb/adr/dat/sel/we are held stable. The counter increments each cycle. Evaluation on each edge, in priority order:
  1. wb_err_i=1 (wins over a simultaneous ack):
     - cyc/stb <= 0, mem_ready <= 1, err_o <= 1, mem_rdata <= 0
     - go to DONE
  2. wb_ack_i=1:
     - cyc/stb <= 0, mem_ready <= 1
     - read: mem_rdata <= wb_dat_i; write: mem_rdata unchanged
     - go to DONE
  3. TIMEOUT!=0 and counter==TIMEOUT-1: handled the same as err.
- DONE: lasts exactly one cycle. mem_ready and err_o are high in this cycle only, then cleared. mem_valid is ignored. Next state is IDLE.
- On exit from DONE, mem_ready/err_o <= 0 and cyc/stb stay 0, so there is a guaranteed idle bus cycle between transfers.
- Latency: the request is sampled at the end of cycle 0 and cyc/stb are high from cycle 1. With a slave that acks one cycle later (ack high in cycle 2), mem_ready is high in cycle 3. The earliest next request is sampled at the end of cycle 4.
- mem_valid dropping while BUSY is a protocol violation. The transfer completes anyway and mem_ready still pulses.
- wb_ack_i or wb_err_i arriving in IDLE or DONE is ignored.
- Timeout counter is 16 bits and never wraps while BUSY, because termination occurs at TIMEOUT-1.

Test Plan:
- Read: responder holds 0xDEADBEEF at 0x00. Drive mem_valid, mem_addr=0x00000000, wstrb=0 -> cyc/stb high in cycle 1 with sel=4'hF, we=0; ack in cycle 2; mem_ready=1 in cycle 3 only; mem_rdata=0xDEADBEEF; err_o=0.
- Byte write: mem_addr=0x00000106, wdata=0x00AB0000, wstrb=4'b0100 -> wb_adr_o=0x00000104, sel=4'b0100, we=1, dat_o=0x00AB0000. Responder reg at 0x04 reads back 0x00AB0000 via sel. mem_rdata keeps its prior value.
- Wait states: responder acks 5 cycles after stb -> cyc/stb and all address/data outputs stay constant for 6 cycles; exactly one mem_ready pulse; no err_o.
- Error priority: wb_ack_i and wb_err_i asserted in the same cycle -> mem_ready=1, err_o=1, mem_rdata=0x00000000.
- Timeout: TIMEOUT=16 with no responder -> cyc/stb high for exactly 16 cycles, then drop; mem_ready and err_o pulse together; mem_rdata=0.
- Reset and back-to-back:
  - Assert arst_i mid-BUSY -> cyc/stb/mem_ready go to 0 without a clock edge; after release a new read completes normally.
  - Hold mem_valid high across two reads -> second cyc rises no earlier than cycle 5, with at least one idle cycle between the two cyc pulses.

Source files
------------

// File: rtl/pico_wb_master.sv
// PicoRV32 native memory port to Wishbone classic single-transfer initiator.
// One mem_valid request becomes one Wishbone cycle; err/timeout end it with zero data.
module pico_wb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        arst_i,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        err_o
);

  localparam int unsigned CntW     = 16;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam bit          TimeoutEn = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            wb_adr_o <= mem_addr & ~32'h3;
            wb_dat_o <= mem_wdata;
            wb_we_o  <= |mem_wstrb;
            wb_sel_o <= (mem_wstrb != 4'h0) ? mem_wstrb : 4'hF;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CntW'(1);
          // err beats ack; ack on the last allowed cycle beats the timeout
          if (wb_err_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            mem_ready <= 1'b1;
            err_o     <= 1'b1;
            mem_rdata <= '0;
            state_q   <= DONE;
          end else if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            mem_ready <= 1'b1;
            if (!wb_we_o) mem_rdata <= wb_dat_i;
            state_q   <= DONE;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            mem_ready <= 1'b1;
            err_o     <= 1'b1;
            mem_rdata <= '0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          err_o     <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_wb_master.sv
// Directed plus randomized bench for pico_wb_master with an in-bench Wishbone responder
// and a transaction-level reference model (latency, outcome, read data).
module tb_pico_wb_master;

  localparam int TO = 16;

  logic        wb_clk_i = 1'b0;
  logic        arst_i;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  logic [31:0] ref_rdata;

  pico_wb_master #(.TIMEOUT(TO)) dut (
    .wb_clk_i (wb_clk_i),
    .arst_i   (arst_i),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .err_o    (err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus gap cycle: DUT must be idle; stray responses are thrown at it.
  task automatic gap();
    @(negedge wb_clk_i);
    wb_ack_i = 1'($urandom);
    wb_err_i = 1'($urandom);
    wb_dat_i = $urandom;
    chk("gap_cyc",   32'(wb_cyc_o),  32'(0));
    chk("gap_stb",   32'(wb_stb_o),  32'(0));
    chk("gap_ready", 32'(mem_ready), 32'(0));
    chk("gap_err",   32'(err_o),     32'(0));
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 no response. lat: cycles after stb rises.
  // policy: 0 drop valid at ready, 1 keep valid high, 2 drop valid after cycle 1.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int lat, input int mode, input int policy);
    int          bl;
    int          rc;
    bit          e;
    logic [31:0] xa;
    logic [3:0]  xs;
    logic [3:0]  idx;
    logic [3:0]  si;
    bl  = (mode == 3 || lat + 1 > TO) ? TO : lat + 1;
    e   = (mode != 0) || (lat + 1 > TO);
    rc  = bl + 1;
    xa  = {addr[31:2], 2'b00};
    xs  = (wstrb != 4'h0) ? wstrb : 4'hF;
    idx = addr[5:2];
    if (e) ref_rdata = 32'h0;
    else if (wstrb != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else ref_rdata = ref_mem[idx];

    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    for (int c = 1; c <= rc; c++) begin
      @(negedge wb_clk_i);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (policy == 2 && c == 1) mem_valid = 1'b0;
      chk("cyc", 32'(wb_cyc_o), 32'(c <= bl));
      chk("stb", 32'(wb_stb_o), 32'(c <= bl));
      if (c <= bl) begin
        chk("adr", wb_adr_o, xa);
        chk("dat", wb_dat_o, wdata);
        chk("sel", 32'(wb_sel_o), 32'(xs));
        chk("we",  32'(wb_we_o), 32'(wstrb != 4'h0));
        if (c == lat + 1 && mode != 3) begin
          wb_ack_i = (mode == 0 || mode == 2);
          wb_err_i = (mode == 1 || mode == 2);
          si = wb_adr_o[5:2];
          if (mode == 0) begin
            if (wb_we_o) begin
              for (int b = 0; b < 4; b++)
                if (wb_sel_o[b]) slv_mem[si][8*b +: 8] = wb_dat_o[8*b +: 8];
            end else wb_dat_i = slv_mem[si];
          end
        end
      end else begin
        wb_ack_i = 1'($urandom);
        wb_err_i = 1'($urandom);
      end
      chk("ready", 32'(mem_ready), 32'(c == rc));
      chk("err",   32'(err_o),     32'(c == rc && e));
      if (c == rc) begin
        chk("rdata", mem_rdata, ref_rdata);
        if (policy != 1) mem_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int r;
    int mode;
    int pol;
    logic [3:0] ws;
    arst_i    = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    wb_dat_i  = '0;
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    ref_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'hDEADBEEF; slv_mem[0] = 32'hDEADBEEF;
    ref_mem[1] = 32'h0;        slv_mem[1] = 32'h0;

    repeat (2) @(negedge wb_clk_i);
    chk("rst_cyc",   32'(wb_cyc_o),  32'(0));
    chk("rst_stb",   32'(wb_stb_o),  32'(0));
    chk("rst_ready", 32'(mem_ready), 32'(0));
    chk("rst_err",   32'(err_o),     32'(0));
    chk("rst_rdata", mem_rdata,      32'h0);
    chk("rst_adr",   wb_adr_o,       32'h0);
    arst_i = 1'b0;
    gap();

    xfer(32'h0000_0000, 32'h1234_5678, 4'b0000, 1, 0, 0); gap();
    xfer(32'h0000_0106, 32'h00AB_0000, 4'b0100, 1, 0, 0); gap();
    xfer(32'h0000_0004, 32'h0,         4'b0000, 1, 0, 0); gap();
    xfer(32'h0000_0008, 32'hCAFE_0001, 4'b0000, 5, 0, 0); gap();
    xfer(32'h0000_000C, 32'h0,         4'b0000, 1, 2, 0); gap();
    xfer(32'h0000_0000, 32'h0,         4'b0000, 0, 0, 0); gap();
    xfer(32'h0000_0010, 32'h0,         4'b0000, 0, 3, 0); gap();
    xfer(32'h0000_0000, 32'h0,         4'b0000, 1, 0, 1); gap();
    xfer(32'h0000_0004, 32'h0,         4'b0000, 1, 0, 0); gap();
    xfer(32'h0000_0000, 32'h0,         4'b0000, 15, 0, 0); gap();
    xfer(32'h0000_0014, 32'h5555_AAAA, 4'b1111, 2, 0, 2); gap();
    xfer(32'h0000_0014, 32'h0,         4'b0000, 0, 0, 0); gap();

    // async reset in the middle of a busy transfer
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0020;
    mem_wstrb = 4'h0;
    @(negedge wb_clk_i);
    chk("pre_rst_cyc", 32'(wb_cyc_o), 32'(1));
    @(negedge wb_clk_i);
    #2 arst_i = 1'b1;
    mem_valid = 1'b0;
    #1;
    chk("mid_rst_cyc",   32'(wb_cyc_o),  32'(0));
    chk("mid_rst_stb",   32'(wb_stb_o),  32'(0));
    chk("mid_rst_ready", 32'(mem_ready), 32'(0));
    chk("mid_rst_rdata", mem_rdata,      32'h0);
    @(negedge wb_clk_i);
    arst_i    = 1'b0;
    ref_rdata = 32'h0;
    gap();
    xfer(32'h0000_0000, 32'h0, 4'b0000, 1, 0, 0); gap();

    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(0, 9);
      mode = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      ws   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      pol  = $urandom_range(0, 2);
      xfer($urandom, $urandom, ws, $urandom_range(0, 18), mode, pol);
      gap();
      if (pol != 1) repeat ($urandom_range(0, 2)) gap();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
